// File: rtl/droid_pkg.sv
// Shared constants for the droid front end: button FSM encodings and sensor indices.
package droid_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE         = 2'b00,
    BTN_PRESS_WAIT   = 2'b01,
    BTN_HELD         = 2'b10,
    BTN_RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int unsigned S1_IDX      = 0;
  localparam int unsigned S2_IDX      = 1;
  localparam int unsigned S3_IDX      = 2;
  localparam int unsigned S4_IDX      = 3;
  localparam int unsigned NUM_SENSORS = S4_IDX + 1;

endpackage

// File: rtl/input_conditioner_if.sv
// Pad-side raw inputs and conditioned outputs of the input conditioner.
interface input_conditioner_if;

  logic                                 b_raw;
  logic [droid_pkg::NUM_SENSORS-1:0]    s_raw;
  logic                                 b_pulse;
  logic                                 b_level;
  logic [droid_pkg::NUM_SENSORS-1:0]    s_clean;
  logic                                 s_change;

  modport master (output b_raw, s_raw, input b_pulse, b_level, s_clean, s_change);
  modport slave  (input b_raw, s_raw, output b_pulse, b_level, s_clean, s_change);

endinterface

// File: rtl/sensor_filter_bit.sv
// One sensor bit: 2-flop synchroniser plus glitch filter requiring FILTER
// consecutive differing samples before the clean level follows.
module sensor_filter_bit #(
  parameter int unsigned FILTER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic upd_c
);

  localparam int unsigned    CW       = $clog2(FILTER);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign differ = sync2 ^ clean;
  assign upd_c  = differ && (cnt == CNT_LAST);

  // Any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (!differ) begin
      cnt   <= '0;
    end else if (upd_c) begin
      cnt   <= '0;
      clean <= sync2;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises, debounces the mode button and glitch-filters the four sensors
// ahead of the mode FSM and motor decoder.
module input_conditioner
  import droid_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SENSOR_FILTER   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input_conditioner_if.slave io
);

  localparam int unsigned   BW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DEBOUNCE_CYCLES - 1);

  logic                   b_sync1;
  logic                   b_sync;
  btn_state_t             state;
  btn_state_t             state_nxt;
  logic [BW-1:0]          bcnt;
  logic [BW-1:0]          bcnt_nxt;
  logic                   pulse_nxt;
  logic                   level_nxt;
  logic                   b_pulse_q;
  logic                   b_level_q;
  logic [NUM_SENSORS-1:0] s_clean_w;
  logic [NUM_SENSORS-1:0] s_upd;
  logic                   s_change_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sync1 <= 1'b0;
      b_sync  <= 1'b0;
    end else begin
      b_sync1 <= io.b_raw;
      b_sync  <= b_sync1;
    end
  end

  // State, counter and registered button outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BTN_IDLE;
      bcnt      <= '0;
      b_pulse_q <= 1'b0;
      b_level_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_nxt;
      b_pulse_q <= pulse_nxt;
      b_level_q <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      BTN_IDLE: begin
        if (b_sync) begin
          state_nxt = BTN_PRESS_WAIT;
          bcnt_nxt  = '0;
        end
      end
      BTN_PRESS_WAIT: begin
        if (!b_sync)                 state_nxt = BTN_IDLE;
        else if (bcnt == BCNT_LAST)  state_nxt = BTN_HELD;
        else                         bcnt_nxt  = bcnt + BW'(1);
      end
      BTN_HELD: begin
        if (!b_sync) begin
          state_nxt = BTN_RELEASE_WAIT;
          bcnt_nxt  = '0;
        end
      end
      BTN_RELEASE_WAIT: begin
        if (b_sync)                  state_nxt = BTN_HELD;
        else if (bcnt == BCNT_LAST)  state_nxt = BTN_IDLE;
        else                         bcnt_nxt  = bcnt + BW'(1);
      end
      default: state_nxt = BTN_IDLE;
    endcase
  end

  // Pulse only on the PRESS_WAIT -> HELD transition, so holding never repeats it.
  always_comb begin
    pulse_nxt = 1'b0;
    level_nxt = 1'b0;
    pulse_nxt = (state == BTN_PRESS_WAIT) && b_sync && (bcnt == BCNT_LAST);
    level_nxt = (state_nxt == BTN_HELD) || (state_nxt == BTN_RELEASE_WAIT);
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
    sensor_filter_bit #(.FILTER(SENSOR_FILTER)) u_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (io.s_raw[i]),
      .clean (s_clean_w[i]),
      .upd_c (s_upd[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_change_q <= 1'b0;
    else     s_change_q <= |s_upd;
  end

  assign io.b_pulse  = b_pulse_q;
  assign io.b_level  = b_level_q;
  assign io.s_clean  = s_clean_w;
  assign io.s_change = s_change_q;

endmodule
